// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counting interval timer with borrow pulse
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_mr,      // master reset, active-low, asynchronous
    input  logic             i_load,    // synchronous load, active-low
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_en,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_q,
    output logic             o_bo,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_preset;
    logic             r_bo;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_next_preset;
    logic             w_next_bo;

    always_ff @(posedge i_clk or negedge i_mr) begin
        if (!i_mr) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_preset <= '0;
            r_bo     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_q      <= w_next_q;
            r_preset <= w_next_preset;
            r_bo     <= w_next_bo;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_q      = r_q;
        w_next_preset = r_preset;
        w_next_bo     = 1'b0;
        if (!i_load) begin
            // Load wins over any terminal count landing on the same edge.
            w_next_q      = i_d;
            w_next_preset = i_d;
            w_next_state  = (i_d != '0) ? RUN : DONE;
        end else begin
            case (r_state)
                IDLE: w_next_q = '0;
                RUN: begin
                    if (!i_en) begin
                        w_next_state = HOLD;
                    end else if (i_tick) begin
                        if (r_q > WIDTH'(1)) begin
                            w_next_q = r_q - WIDTH'(1);
                        end else begin
                            // Terminal count; also catches Q==0 so the count never wraps.
                            w_next_bo = 1'b1;
                            if (AUTO_RELOAD) begin
                                w_next_q = r_preset;
                            end else begin
                                w_next_q     = '0;
                                w_next_state = DONE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (i_en) begin
                        w_next_state = RUN;
                    end
                end
                DONE: w_next_q = '0;
                default: begin
                    w_next_state = IDLE;
                    w_next_q     = '0;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_bo   = r_bo;
    assign o_busy = (r_state == RUN) || (r_state == HOLD);
    assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer, one-shot and auto-reload instances
module tb_countdown_timer;

    logic       clk;
    logic       mr;
    logic       load;
    logic [3:0] d;
    logic       en;
    logic       tick;

    logic [3:0] q0, q1;
    logic       bo0, bo1, busy0, busy1, done0, done1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        int         which;
        logic [3:0] q;
        logic       bo;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_oneshot (
        .i_clk(clk), .i_mr(mr), .i_load(load), .i_d(d), .i_en(en), .i_tick(tick),
        .o_q(q0), .o_bo(bo0), .o_busy(busy0), .o_done(done0)
    );

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
        .i_clk(clk), .i_mr(mr), .i_load(load), .i_d(d), .i_en(en), .i_tick(tick),
        .o_q(q1), .o_bo(bo1), .o_busy(busy1), .o_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int which, input logic [3:0] eq,
                         input logic ebo, input logic ebusy, input logic edone);
        logic [3:0] aq;
        logic       abo, abusy, adone;
        if (which == 0) begin
            aq = q0; abo = bo0; abusy = busy0; adone = done0;
        end else begin
            aq = q1; abo = bo1; abusy = busy1; adone = done1;
        end
        n_checks++;
        if ({aq, abo, abusy, adone} !== {eq, ebo, ebusy, edone}) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got q=%0d bo=%0b busy=%0b done=%0b, expected q=%0d bo=%0b busy=%0b done=%0b",
                     name, which, aq, abo, abusy, adone, eq, ebo, ebusy, edone);
        end
    endtask

    // Monitor: every edge that had stimulus queued is compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.name, e.which, e.q, e.bo, e.busy, e.done);
            end
        end
    end

    task automatic step(input string name, input logic ld, input logic [3:0] dv,
                        input logic ev, input logic tv, input int which,
                        input logic [3:0] eq, input logic ebo, input logic ebusy,
                        input logic edone);
        exp_t e;
        @(negedge clk);
        load = ld; d = dv; en = ev; tick = tv;
        e.name = name; e.which = which; e.q = eq; e.bo = ebo; e.busy = ebusy; e.done = edone;
        sb.push_back(e);
    endtask

    initial begin
        mr = 1'b0; load = 1'b1; d = 4'd0; en = 1'b0; tick = 1'b0;
        #2;
        check("reset_oneshot", 0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset_reload",  1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        mr = 1'b1;

        // IDLE ignores EN/TICK
        step("idle_ignore", 1'b1, 4'd7, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b0);
        step("idle_ignore", 1'b1, 4'd7, 1'b1, 1'b1, 1, 4'd0, 1'b0, 1'b0, 1'b0);

        // One-shot countdown from 3
        step("os_load3", 1'b0, 4'd3, 1'b1, 1'b1, 0, 4'd3, 1'b0, 1'b1, 1'b0);
        step("os_q2",    1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd2, 1'b0, 1'b1, 1'b0);
        step("os_q1",    1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd1, 1'b0, 1'b1, 1'b0);
        step("os_term",  1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b1, 1'b0, 1'b1);
        step("os_done1", 1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("os_done2", 1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Auto-reload with preset 4, TICK every cycle for 12 cycles
        step("ar_load4", 1'b0, 4'd4, 1'b1, 1'b1, 1, 4'd4, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] eq;
            logic       ebo;
            ebo = (k % 4 == 0);
            eq  = ebo ? 4'd4 : 4'(4 - (k % 4));
            step($sformatf("ar_tick%0d", k), 1'b1, 4'd0, 1'b1, 1'b1, 1, eq, ebo, 1'b1, 1'b0);
        end

        // Pause/resume: reach Q=2, hold 3 cycles with TICK, resume edge ignores TICK
        step("hd_load5", 1'b0, 4'd5, 1'b1, 1'b0, 1, 4'd5, 1'b0, 1'b1, 1'b0);
        step("hd_q4",    1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd4, 1'b0, 1'b1, 1'b0);
        step("hd_q3",    1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd3, 1'b0, 1'b1, 1'b0);
        step("hd_q2",    1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd2, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            step("hd_paused", 1'b1, 4'd0, 1'b0, 1'b1, 1, 4'd2, 1'b0, 1'b1, 1'b0);
        step("hd_resume", 1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd2, 1'b0, 1'b1, 1'b0);
        step("hd_q1",     1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd1, 1'b0, 1'b1, 1'b0);

        // Load beats terminal count on the same edge
        step("ld_over_term", 1'b0, 4'd9, 1'b1, 1'b1, 1, 4'd9, 1'b0, 1'b1, 1'b0);
        step("ld_run_q8",    1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd8, 1'b0, 1'b1, 1'b0);

        // Zero preset goes straight to DONE
        step("zero_load", 1'b0, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("zero_tick", 1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("zero_tick", 1'b1, 4'd0, 1'b1, 1'b1, 0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-count with Q=5
        step("mr_load5", 1'b0, 4'd5, 1'b1, 1'b0, 1, 4'd5, 1'b0, 1'b1, 1'b0);
        step("mr_q5",    1'b1, 4'd0, 1'b1, 1'b0, 1, 4'd5, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        mr = 1'b0;
        #1;
        check("mr_async", 1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mr = 1'b1;
        step("mr_idle", 1'b1, 4'd0, 1'b1, 1'b1, 1, 4'd0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && sb.size() != 0; k++)
            @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
